// File: rtl/cc_cond_unit.sv
// cc_cond_unit: execute-stage consumer of ALU results. Maintains the Y86-64
// condition codes (ZF/SF/OF), evaluates the jXX/cmovXX condition and hands
// valE plus Cnd to the memory stage through a valid/ready output register.
module cc_cond_unit #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_ovf,
    input  logic [1:0]       alu_op,
    input  logic             set_cc,
    input  logic [3:0]       ifun,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] val_e,
    output logic             cnd,
    output logic             bad_ifun,
    output logic             zf,
    output logic             sf,
    output logic             of
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;

    localparam logic [3:0] C_ALWAYS = 4'd0;
    localparam logic [3:0] C_LE     = 4'd1;
    localparam logic [3:0] C_L      = 4'd2;
    localparam logic [3:0] C_E      = 4'd3;
    localparam logic [3:0] C_NE     = 4'd4;
    localparam logic [3:0] C_GE     = 4'd5;
    localparam logic [3:0] C_G      = 4'd6;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_val_e;
    logic             r_cnd;
    logic             r_bad_ifun;
    logic             r_zf;
    logic             r_sf;
    logic             r_of;

    logic             w_accept;
    logic             w_sxo;
    logic             w_cnd;
    logic             w_bad;

    // Skid-free output stage: free slot or slot draining this cycle.
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Condition evaluated on the flags held before this transaction's update.
    always_comb begin
        w_sxo = r_sf ^ r_of;
        w_cnd = 1'b0;
        w_bad = 1'b0;
        case (ifun)
            C_ALWAYS: w_cnd = 1'b1;
            C_LE:     w_cnd = w_sxo | r_zf;
            C_L:      w_cnd = w_sxo;
            C_E:      w_cnd = r_zf;
            C_NE:     w_cnd = !r_zf;
            C_GE:     w_cnd = !w_sxo;
            C_G:      w_cnd = !w_sxo && !r_zf;
            default:  w_bad = 1'b1;
        endcase
    end

    // Output register: load on accept, clear valid when drained with nothing new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_val_e     <= '0;
            r_cnd       <= 1'b0;
            r_bad_ifun  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_val_e     <= alu_out;
            r_cnd       <= w_cnd;
            r_bad_ifun  <= w_bad;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Condition-code register: updated only by accepted OPq transactions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zf <= 1'b1;
            r_sf <= 1'b0;
            r_of <= 1'b0;
        end else if (w_accept && set_cc) begin
            r_zf <= (alu_out == '0);
            r_sf <= alu_out[WIDTH-1];
            r_of <= ((alu_op == OP_ADD) || (alu_op == OP_SUB)) ? alu_ovf : 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign val_e     = r_val_e;
    assign cnd       = r_cnd;
    assign bad_ifun  = r_bad_ifun;
    assign zf        = r_zf;
    assign sf        = r_sf;
    assign of        = r_of;

endmodule

// File: tb/tb_cc_cond_unit.sv
// Directed + randomized bench for cc_cond_unit with a lock-step reference
// model of the condition codes and a queue of expected output beats.
module tb_cc_cond_unit;

    localparam int unsigned WIDTH = 64;

    typedef struct packed {
        logic [WIDTH-1:0] v;
        logic             c;
        logic             b;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] alu_out;
    logic             alu_ovf;
    logic [1:0]       alu_op;
    logic             set_cc;
    logic [3:0]       ifun;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] val_e;
    logic             cnd;
    logic             bad_ifun;
    logic             zf;
    logic             sf;
    logic             of;

    int   n_assert = 0;
    int   n_fail   = 0;

    exp_t q[$];
    exp_t m_last;
    logic m_ov;
    logic m_zf, m_sf, m_of;

    cc_cond_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_out   (alu_out),
        .alu_ovf   (alu_ovf),
        .alu_op    (alu_op),
        .set_cc    (set_cc),
        .ifun      (ifun),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .val_e     (val_e),
        .cnd       (cnd),
        .bad_ifun  (bad_ifun),
        .zf        (zf),
        .sf        (sf),
        .of        (of)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns {bad_ifun, cnd} from the jXX/cmovXX table.
    function automatic logic [1:0] model_cond(input logic [3:0] f, input logic z, input logic s, input logic o);
        case (f)
            4'd0:    return 2'b01;
            4'd1:    return {1'b0, (s ^ o) | z};
            4'd2:    return {1'b0, s ^ o};
            4'd3:    return {1'b0, z};
            4'd4:    return {1'b0, ~z};
            4'd5:    return {1'b0, ~(s ^ o)};
            4'd6:    return {1'b0, ~(s ^ o) & ~z};
            default: return 2'b10;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        m_last = '0;
        m_ov   = 1'b0;
        m_zf   = 1'b1;
        m_sf   = 1'b0;
        m_of   = 1'b0;
    endtask

    // One clock: check outputs against the model, advance model, step clock.
    task automatic tick(output bit acc);
        bit   xfer;
        exp_t e;
        logic [1:0] cb;
        #1;
        chk("in_ready", WIDTH'(in_ready), WIDTH'(!m_ov || out_ready));
        chk("out_valid", WIDTH'(out_valid), WIDTH'(m_ov));
        if (m_ov && q.size() > 0) e = q[0];
        else                      e = m_last;
        chk("val_e", val_e, e.v);
        chk("cnd", WIDTH'(cnd), WIDTH'(e.c));
        chk("bad_ifun", WIDTH'(bad_ifun), WIDTH'(e.b));
        chk("zf", WIDTH'(zf), WIDTH'(m_zf));
        chk("sf", WIDTH'(sf), WIDTH'(m_sf));
        chk("of", WIDTH'(of), WIDTH'(m_of));
        acc  = in_valid && (!m_ov || out_ready);
        xfer = m_ov && out_ready;
        if (xfer && q.size() > 0) m_last = q.pop_front();
        if (acc) begin
            cb = model_cond(ifun, m_zf, m_sf, m_of);
            q.push_back('{v: alu_out, c: cb[0], b: cb[1]});
            if (set_cc) begin
                m_zf = (alu_out == '0);
                m_sf = alu_out[WIDTH-1];
                m_of = (alu_op == 2'b00 || alu_op == 2'b01) ? alu_ovf : 1'b0;
            end
        end
        m_ov = acc ? 1'b1 : (xfer ? 1'b0 : m_ov);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one transaction and hold it until accepted (bounded).
    task automatic send(input logic [WIDTH-1:0] v, input logic ovf, input logic [1:0] op,
                        input logic sc, input logic [3:0] f);
        bit acc;
        int n;
        in_valid = 1'b1;
        alu_out  = v;
        alu_ovf  = ovf;
        alu_op   = op;
        set_cc   = sc;
        ifun     = f;
        acc      = 1'b0;
        n        = 0;
        while (!acc && n < 20) begin
            tick(acc);
            n++;
        end
        chk("accept_timeout", WIDTH'(acc), WIDTH'(1'b1));
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    initial begin
        bit acc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        alu_out   = '0;
        alu_ovf   = 1'b0;
        alu_op    = 2'b00;
        set_cc    = 1'b0;
        ifun      = 4'd0;
        out_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state, then ifun=e with Z=1 from reset.
        idle(2);
        chk("reset_zf_const", WIDTH'(zf), WIDTH'(1'b1));
        send(64'h1234, 1'b0, 2'b00, 1'b0, 4'd3);
        idle(1);

        // Negative result from sub: Z=0 S=1 O=0; then l taken, g not taken.
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'b01, 1'b1, 4'd0);
        send(64'h1, 1'b0, 2'b00, 1'b0, 4'd2);
        send(64'h2, 1'b0, 2'b00, 1'b0, 4'd6);
        idle(1);
        chk("flags_neg", WIDTH'({zf, sf, of}), WIDTH'(3'b010));

        // Overflowing add sets OF; logical op clears OF despite alu_ovf.
        send(64'h8000_0000_0000_0000, 1'b1, 2'b00, 1'b1, 4'd1);
        idle(1);
        chk("flags_ovf", WIDTH'({zf, sf, of}), WIDTH'(3'b011));
        send(64'h0, 1'b1, 2'b10, 1'b1, 4'd5);
        idle(1);
        chk("flags_and", WIDTH'({zf, sf, of}), WIDTH'(3'b100));

        // Back-pressure for 3 cycles, then 8 back-to-back transfers.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            alu_out = (i % 3 == 1) ? '0 : WIDTH'(64'h100 + i);
            alu_ovf = i[0];
            alu_op  = i[1:0];
            set_cc  = 1'b1;
            ifun    = 4'(i % 7);
            acc     = 1'b0;
            for (int n = 0; n < 20 && !acc; n++) begin
                out_ready = (i >= 2) || (i == 1 && n >= 3);
                tick(acc);
            end
            chk("bp_accept", WIDTH'(acc), WIDTH'(1'b1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(2);

        // Illegal ifun: cnd=0, bad_ifun=1, flags still update.
        send(64'h5, 1'b0, 2'b00, 1'b1, 4'd9);
        send(64'h0, 1'b0, 2'b11, 1'b0, 4'd15);
        idle(1);
        chk("flags_bad", WIDTH'({zf, sf, of}), WIDTH'(3'b000));

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 60; i++) begin
            in_valid  = 1'($urandom % 2);
            alu_out   = ($urandom % 4 == 0) ? '0 : {$urandom, $urandom};
            alu_ovf   = 1'($urandom % 2);
            alu_op    = 2'($urandom % 4);
            set_cc    = 1'($urandom % 2);
            ifun      = 4'($urandom % 10);
            out_ready = ($urandom % 4) != 0;
            tick(acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(3);
        chk("queue_drained", WIDTH'(q.size()), WIDTH'(0));

        // Async reset mid-cycle while holding a valid output.
        send(64'h7, 1'b0, 2'b00, 1'b1, 4'd0);
        out_ready = 1'b0;
        idle(1);
        chk("pre_rst_valid", WIDTH'({out_valid, cnd, zf}), WIDTH'(3'b110));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", WIDTH'({out_valid, cnd, zf, sf, of}), WIDTH'(5'b00100));
        chk("async_rst_vale", val_e, '0);
        model_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle(2);
        send(64'h0, 1'b0, 2'b00, 1'b0, 4'd3);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
